// File: rtl/alu_pkg.sv
// Op-code constants and controller state type shared by the pipelined ALU
// and its bench.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_SLT  = 5'b00010;
    localparam logic [4:0] OP_SLTU = 5'b00011;
    localparam logic [4:0] OP_NOR  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_XOR  = 5'b00111;
    localparam logic [4:0] OP_SLL  = 5'b01000;
    localparam logic [4:0] OP_SRL  = 5'b01001;
    localparam logic [4:0] OP_SRA  = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01011;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/mul_seq.sv
// Shift-add multiplier: one multiplier bit per cycle, WIDTH iterations after
// start. done/P are valid combinationally during the final iteration cycle.
module mul_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             done,
    output logic [WIDTH-1:0] P
);

    localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH - 1);

    logic             busy;
    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_next;

    assign acc_next = mplier[0] ? (acc + mcand) : acc;
    assign done     = busy && (cnt == LAST);
    // Product is taken from the last partial sum so the top can load it on
    // the same edge that completes the final iteration.
    assign P        = acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= A;
            mplier <= B;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipelined_alu.sv
// Single-stage ALU with valid/ready handshakes; MUL detours through the
// iterative multiplier and blocks new operations until it finishes.
//
// state | meaning
// IDLE  | accepting operations, simple results land in one cycle
// MUL   | multiplier iterating, input side stalled
module pipelined_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    state_t           state;
    logic             accept;
    logic             mul_start;
    logic             simple_load;
    logic             mul_load;
    logic             mul_done;
    logic [WIDTH-1:0] mul_p;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res;
    logic             res_ovf;
    logic             res_err;

    assign in_ready    = (state == IDLE) && (!out_valid || out_ready);
    assign accept      = in_valid && in_ready;
    assign mul_start   = accept && (Op == OP_MUL);
    assign simple_load = accept && (Op != OP_MUL);
    assign mul_load    = (state == MUL) && mul_done;

    assign sum   = A + B;
    assign diff  = A - B;
    assign shamt = B[SHW-1:0];

    always_comb begin
        res     = '0;
        res_ovf = 1'b0;
        res_err = 1'b0;
        case (Op)
            OP_ADD: begin
                res     = sum;
                res_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                res     = diff;
                res_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, A < B};
            OP_NOR:  res = ~(A | B);
            OP_AND:  res = A & B;
            OP_OR:   res = A | B;
            OP_XOR:  res = A ^ B;
            OP_SLL:  res = A << shamt;
            OP_SRL:  res = A >> shamt;
            OP_SRA:  res = $unsigned($signed(A) >>> shamt);
            OP_MUL:  res = '0;
            default: res_err = 1'b1;
        endcase
    end

    mul_seq #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .A     (A),
        .B     (B),
        .done  (mul_done),
        .P     (mul_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            R         <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (mul_start) state <= MUL;
                MUL:     if (mul_done)  state <= IDLE;
                default: state <= IDLE;
            endcase

            // Result register only moves on a load, so it holds under backpressure.
            if (simple_load) begin
                R         <= res;
                zero      <= (res == '0);
                ovf       <= res_ovf;
                err       <= res_err;
                out_valid <= 1'b1;
            end else if (mul_load) begin
                R         <= mul_p;
                zero      <= (mul_p == '0);
                ovf       <= 1'b0;
                err       <= 1'b0;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_alu.sv
// Directed bench for pipelined_alu: transaction-level reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_pipelined_alu;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  Op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] R;
    logic        zero;
    logic        ovf;
    logic        err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit started  = 0;
    bit rdy_rand = 0;

    pipelined_alu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Op        (Op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R),
        .zero      (zero),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference semantics in plain integer arithmetic.
    function automatic void ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic o, output logic e);
        longint sa;
        longint sb;
        longint t;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        r = 32'd0;
        o = 1'b0;
        e = 1'b0;
        case (op)
            OP_ADD:  begin t = sa + sb; r = t[31:0]; o = (t != longint'($signed(r))); end
            OP_SUB:  begin t = sa - sb; r = t[31:0]; o = (t != longint'($signed(r))); end
            OP_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            OP_NOR:  r = ~(a | b);
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << b[4:0];
            OP_SRL:  r = a >> b[4:0];
            OP_SRA:  begin t = sa >>> b[4:0]; r = t[31:0]; end
            OP_MUL:  begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
            default: e = 1'b1;
        endcase
    endfunction

    // Transaction model: result register contents and cycles left on a MUL.
    logic [31:0] m_r = 0, m_mul = 0, nr;
    logic        m_z = 0, m_o = 0, m_e = 0, m_valid = 0, m_busy = 0;
    logic        no, ne, ld, m_rdy;
    int          m_left = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 0; m_busy = 0; m_left = 0;
            m_r = 0; m_z = 0; m_o = 0; m_e = 0;
        end else begin
            m_rdy = !m_busy && (!m_valid || out_ready);
            ld = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; ld = 1; nr = m_mul; no = 0; ne = 0;
                end
            end else if (in_valid && m_rdy) begin
                ref_op(Op, A, B, nr, no, ne);
                if (Op == OP_MUL) begin
                    m_busy = 1; m_left = WIDTH; m_mul = nr;
                end else begin
                    ld = 1;
                end
            end
            if (ld) begin
                m_valid = 1; m_r = nr; m_z = (nr == 0); m_o = no; m_e = ne;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
    end

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        o;
        logic        e;
        int          c;
    } ent_t;
    ent_t log_q[$];

    always @(negedge clk) begin
        if (started) begin
            chk1("cyc_in_ready", in_ready, !m_busy && (!m_valid || out_ready));
            chk1("cyc_out_valid", out_valid, m_valid);
            if (m_valid) begin
                chk32("cyc_R", R, m_r);
                chk1("cyc_zero", zero, m_z);
                chk1("cyc_ovf", ovf, m_o);
                chk1("cyc_err", err, m_e);
            end
            if (out_valid && out_ready)
                log_q.push_back('{R, zero, ovf, err, cyc});
        end
    end

    // Leaves in_valid high on return so calls can chain back-to-back.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int  n;
        bit  acc;
        n = 0;
        Op = op; A = a; B = b; in_valid = 1;
        while (1) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #2;
            if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
            if (acc) break;
            n++;
            if (n > 200) begin
                total++; bad++;
                $display("FAIL issue_timeout: op %b not accepted within 200 cycles", op);
                break;
            end
        end
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        o;
    } vec_t;
    vec_t vec[13];

    initial begin
        int n;
        int hits;
        vec = '{
            '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1},
            '{OP_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0},
            '{OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0},
            '{OP_NOR,  32'h0F0F0000, 32'h00F0F000, 32'hF0000FFF, 1'b0},
            '{OP_AND,  32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0},
            '{OP_OR,   32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0},
            '{OP_XOR,  32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b0},
            '{OP_SLL,  32'h00000003, 32'h00000021, 32'h00000006, 1'b0},
            '{OP_SRL,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0},
            '{OP_SRA,  32'h7FFFFFF0, 32'h00000004, 32'h07FFFFFF, 1'b0},
            '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0},
            '{OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0},
            '{OP_MUL,  32'h00000003, 32'h00000000, 32'h00000000, 1'b0}
        };

        rst = 1; in_valid = 0; A = 0; B = 0; Op = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        #2;
        rst = 0;
        started = 1;

        @(negedge clk);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk32("rst_R", R, 32'h0);
        chk1("rst_zero", zero, 1'b0);
        chk1("rst_ovf", ovf, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #2;

        // signed overflow on ADD
        out_ready = 1;
        issue(OP_ADD, 32'h7FFFFFFF, 32'h00000001);
        in_valid = 0;
        @(negedge clk);
        chk1("add_valid", out_valid, 1'b1);
        chk32("add_R", R, 32'h80000000);
        chk1("add_ovf", ovf, 1'b1);
        chk1("add_zero", zero, 1'b0);
        chk1("add_err", err, 1'b0);
        @(posedge clk);
        #2;

        // back-to-back SUB then SLT, one result per cycle
        log_q.delete();
        issue(OP_SUB, 32'd5, 32'd5);
        issue(OP_SLT, 32'hFFFFFFFF, 32'd1);
        in_valid = 0;
        repeat (3) @(posedge clk);
        #2;
        chk32("b2b_count", log_q.size(), 32'd2);
        if (log_q.size() >= 2) begin
            chk32("b2b_R0", log_q[0].r, 32'h0);
            chk1("b2b_zero0", log_q[0].z, 1'b1);
            chk32("b2b_R1", log_q[1].r, 32'h1);
            chk1("b2b_zero1", log_q[1].z, 1'b0);
            chk32("b2b_spacing", log_q[1].c - log_q[0].c, 32'd1);
        end

        // MUL latency; operand changes during iteration must not matter
        issue(OP_MUL, 32'h00012345, 32'h00000100);
        in_valid = 0;
        A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; Op = OP_ADD;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        chk32("mul_busy_cycles", n, 32'd32);
        chk1("mul_valid", out_valid, 1'b1);
        chk32("mul_R", R, 32'h01234500);
        @(posedge clk);
        #2;

        // SRA held under backpressure
        out_ready = 0;
        issue(OP_SRA, 32'h80000000, 32'd4);
        in_valid = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk32("sra_R_held", R, 32'hF8000000);
            chk1("sra_valid_held", out_valid, 1'b1);
            chk1("sra_in_ready_low", in_ready, 1'b0);
            @(posedge clk);
            #2;
        end
        out_ready = 1;
        @(negedge clk);
        chk1("sra_in_ready_release", in_ready, 1'b1);
        @(posedge clk);
        #2;
        @(negedge clk);
        chk1("sra_consumed", out_valid, 1'b0);
        @(posedge clk);
        #2;

        // undefined op
        issue(5'b11111, 32'h1234, 32'h5678);
        in_valid = 0;
        @(negedge clk);
        chk32("undef_R", R, 32'h0);
        chk1("undef_err", err, 1'b1);
        chk1("undef_zero", zero, 1'b1);
        chk1("undef_ovf", ovf, 1'b0);
        @(posedge clk);
        #2;

        // reset at MUL iteration 10 abandons the product
        issue(OP_MUL, 32'd7, 32'd9);
        in_valid = 0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1;
        @(posedge clk);
        #2;
        rst = 0;
        @(negedge clk);
        chk1("rstmul_in_ready", in_ready, 1'b1);
        chk1("rstmul_out_valid", out_valid, 1'b0);
        hits = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) hits++;
        end
        chk32("rstmul_no_result", hits, 32'd0);
        @(posedge clk);
        #2;

        // vector table with random backpressure
        log_q.delete();
        rdy_rand = 1;
        foreach (vec[i]) issue(vec[i].op, vec[i].a, vec[i].b);
        in_valid = 0;
        n = 0;
        while (log_q.size() < 13 && n < 500) begin
            @(posedge clk);
            #2;
            out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        rdy_rand = 0;
        out_ready = 1;
        chk32("vec_count", log_q.size(), 32'd13);
        foreach (vec[i]) begin
            if (i < log_q.size()) begin
                chk32($sformatf("vec%0d_R", i), log_q[i].r, vec[i].r);
                chk1($sformatf("vec%0d_ovf", i), log_q[i].o, vec[i].o);
                chk1($sformatf("vec%0d_zero", i), log_q[i].z, vec[i].r == 32'h0);
            end
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipelined_alu.md
PIPELINED_ALU -- requirements
Module: pipelined_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width; derived, not overridden.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand/op presented.
REQ-006 SHALL have port in_ready  output  1  block accepts the operation this cycle.
REQ-007 SHALL have port A  input  WIDTH  operand A.
REQ-008 SHALL have port B  input  WIDTH  operand B; B[SHW-1:0] is the shift amount for shifts.
REQ-009 SHALL have port Op  input  5  operation code.
REQ-010 SHALL have port out_valid  output  1  result register holds an unconsumed result.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-012 SHALL have port R  output  WIDTH  result.
REQ-013 SHALL have port zero  output  1  R == 0.
REQ-014 SHALL have port ovf  output  1  signed overflow; ADD/SUB only, else 0.
REQ-015 SHALL have port err  output  1  Op was not a defined code.

Function
REQ-016 Op codes SHALL be: ADD 00000, SUB 00001, SLT 00010, SLTU 00011, NOR 00100, AND 00101, OR 00110, XOR 00111, SLL 01000, SRL 01001, SRA 01010, MUL 01011.
REQ-017 Undefined Op SHALL produce R=0, err=1, zero=1, with the same 1-cycle latency as simple ops.
REQ-018 Arithmetic SHALL be modulo 2^WIDTH; SLT/SLTU SHALL give R = {WIDTH-1 zeros, result bit}; MUL SHALL give the low WIDTH bits of A*B.
REQ-019 ovf SHALL be 1 for ADD when A and B share a sign and R differs from it, and for SUB when A and B differ in sign and R differs from A's sign.
REQ-020 A transfer SHALL occur on in_valid && in_ready; out handshake SHALL occur on out_valid && out_ready.
REQ-021 in_ready SHALL equal (state == IDLE) && (!out_valid || out_ready), combinationally.
REQ-022 Simple ops (all except MUL) accepted at edge N SHALL present out_valid=1 with R/flags after edge N+1.
REQ-023 FSM states SHALL be IDLE and MUL; IDLE->MUL on accepting MUL; MUL->IDLE after exactly WIDTH iteration cycles.
REQ-024 MUL accepted at edge N SHALL load the result register at edge N+WIDTH and assert out_valid from then on; in_ready SHALL be 0 throughout MUL.
REQ-025 MUL SHALL be shift-add, one multiplier bit per cycle, with an iteration counter of SHW+1 bits.
REQ-026 R, zero, ovf, err SHALL stay stable while out_valid && !out_ready.
REQ-027 out_valid SHALL clear on consumption unless a new result loads on the same edge; simultaneous consume and accept SHALL sustain one result per cycle for simple ops.
REQ-028 Operands SHALL be captured on acceptance; changes to A/B/Op during MUL SHALL have no effect.

Reset
REQ-029 rst=1 at an edge SHALL force state=IDLE, out_valid=0, R=0, zero=0, ovf=0, err=0, and clear the MUL counter and accumulator.
REQ-030 rst asserted mid-MUL SHALL abandon the operation with no result; in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-031 Op code constants and the FSM state type SHALL live in shared package alu_pkg.
REQ-032 The iterative multiplier SHALL be sub-module mul_seq (start, A, B -> done, P), parametrised by WIDTH.

Verification
REQ-033 ADD A=0x7FFFFFFF, B=1 -> one cycle later R=0x80000000, ovf=1, zero=0, err=0.
REQ-034 SUB A=5, B=5 then SLT A=0xFFFFFFFF, B=1 back-to-back, out_ready=1 -> R=0, zero=1; then R=1; one result per cycle.
REQ-035 MUL A=0x12345, B=0x100 -> in_ready=0 for 32 cycles, then R=0x01234500, out_valid=1.
REQ-036 SRA A=0x80000000, B=4 with out_ready=0 for 3 cycles -> R=0xF8000000 held stable, in_ready=0 until consumed.
REQ-037 Op=11111 -> R=0, err=1, zero=1; rst pulsed at MUL iteration 10 -> no out_valid, in_ready=1 the cycle after reset.
